// File: rtl/embedded_system_led_sequencer.sv
// rtl/embedded_system_led_sequencer.sv - Avalon-MM LED pattern sequencer (blink/scan/bar); optional LED_SEQ_IRQ_EN adds irq_enable and done interrupt
module embedded_system_led_sequencer #(
  parameter int LED_WIDTH    = 10,
  parameter int PERIOD_WIDTH = 24,
  parameter int RESET_PERIOD = 5000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic [LED_WIDTH-1:0] out_port,
  output logic                 irq
);

  localparam int POS_W = $clog2(LED_WIDTH);
  localparam int LVL_W = $clog2(LED_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              mode_q;
  logic                    loop_q;
  logic                    irq_en_q;
  logic [LED_WIDTH-1:0]    direct_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [7:0]              count_q;
  logic                    done_q;
  logic [7:0]              steps_q;
  logic [PERIOD_WIDTH-1:0] presc_q;
  logic                    phase_q;
  logic [POS_W-1:0]        pos_q;
  logic                    dir_up_q;
  logic [LVL_W-1:0]        level_q;
  logic                    just_done_q;
  logic [LED_WIDTH-1:0]    frame;

  logic                    we;
  logic                    start;
  logic                    stop;
  logic [PERIOD_WIDTH-1:0] period_m1;
  logic [7:0]              eff_count;
  logic                    tick;
  logic                    adv;
  logic                    finish;
  logic                    unused_bits;

  assign we        = chipselect && !write_n;
  assign start     = we && (address == 3'd0) && writedata[3];
  assign stop      = we && (address == 3'd0) && writedata[4];
  // A zero period or count is treated as one.
  assign period_m1 = (period_q == '0) ? '0 : period_q - 1'b1;
  assign eff_count = (count_q == 8'd0) ? 8'd1 : count_q;
  assign tick      = (state_q == ST_RUN) && (presc_q >= period_m1);
  // Start restarts and stop aborts, so neither lets a coinciding tick step.
  assign adv       = tick && !start && !stop;
  assign finish    = adv && !loop_q && (({1'b0, steps_q} + 9'd1) >= {1'b0, eff_count});
  assign unused_bits = &{1'b0, writedata[31:PERIOD_WIDTH]};

`ifdef LED_SEQ_IRQ_EN
  // Interrupt enable lives in CTRL[7].
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
    end else if (we && address == 3'd0) begin
      irq_en_q <= writedata[7];
    end
  end
  assign irq = done_q & irq_en_q;
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: stop beats start, start beats one-shot completion.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_RUN;
    end else if (finish) begin
      state_d = ST_DONE;
    end
  end

  // Pattern frame from the engine state for the current mode.
  always_comb begin
    frame = direct_q;
    case (mode_q)
      2'd1: frame = phase_q ? direct_q : '0;
      2'd2: for (int i = 0; i < LED_WIDTH; i++) frame[i] = (pos_q == POS_W'(i));
      2'd3: for (int i = 0; i < LED_WIDTH; i++) frame[i] = (LVL_W'(i) < level_q);
      default: frame = direct_q;
    endcase
  end

  // Registers, prescaler, step counter, engine and LED drive.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q      <= 2'd0;
      loop_q      <= 1'b0;
      direct_q    <= '0;
      period_q    <= PERIOD_WIDTH'(RESET_PERIOD);
      count_q     <= 8'd0;
      done_q      <= 1'b0;
      steps_q     <= 8'd0;
      presc_q     <= '0;
      phase_q     <= 1'b0;
      pos_q       <= '0;
      dir_up_q    <= 1'b0;
      level_q     <= '0;
      just_done_q <= 1'b0;
      out_port    <= '0;
    end else begin
      if (we) begin
        case (address)
          3'd0: begin
            mode_q <= writedata[1:0];
            loop_q <= writedata[2];
          end
          3'd1: direct_q <= writedata[LED_WIDTH-1:0];
          3'd2: period_q <= writedata[PERIOD_WIDTH-1:0];
          3'd3: count_q  <= writedata[7:0];
          default: ;
        endcase
      end

      // Completion wins over a simultaneous software clear.
      if (finish) begin
        done_q <= 1'b1;
      end else if (we && address == 3'd4 && writedata[1]) begin
        done_q <= 1'b0;
      end

      if (start && !stop) begin
        presc_q  <= '0;
        steps_q  <= 8'd0;
        phase_q  <= 1'b1;
        pos_q    <= '0;
        dir_up_q <= 1'b1;
        level_q  <= '0;
      end else if (state_q == ST_RUN && !stop) begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
        if (adv) begin
          steps_q <= steps_q + 8'd1;
          phase_q <= ~phase_q;
          if (dir_up_q) begin
            if (pos_q == POS_W'(LED_WIDTH - 1)) begin
              dir_up_q <= 1'b0;
              pos_q    <= pos_q - 1'b1;
            end else begin
              pos_q <= pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              dir_up_q <= 1'b1;
              pos_q    <= pos_q + 1'b1;
            end else begin
              pos_q <= pos_q - 1'b1;
            end
          end
          level_q <= (level_q == LVL_W'(LED_WIDTH)) ? '0 : level_q + 1'b1;
        end
      end

      // DONE shows the frame from the final tick once, then holds it.
      just_done_q <= finish;
      case (state_q)
        ST_RUN:  out_port <= frame;
        ST_DONE: if (just_done_q) out_port <= frame;
        default: out_port <= direct_q;
      endcase
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata = {24'd0, irq_en_q, state_q, 2'b00, loop_q, mode_q};
      3'd1: readdata[LED_WIDTH-1:0] = direct_q;
      3'd2: readdata[PERIOD_WIDTH-1:0] = period_q;
      3'd3: readdata[7:0] = count_q;
      3'd4: readdata = {16'd0, steps_q, 6'd0, done_q, (state_q == ST_RUN)};
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_embedded_system_led_sequencer.sv
// tb/tb_embedded_system_led_sequencer.sv - directed self-checking bench for embedded_system_led_sequencer
module tb_embedded_system_led_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [9:0]  out_port;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

`ifdef LED_SEQ_IRQ_EN
  localparam logic [31:0] IRQ_BIT = 32'h80;
  localparam logic        EXP_IRQ = 1'b1;
`else
  localparam logic [31:0] IRQ_BIT = 32'h00;
  localparam logic        EXP_IRQ = 1'b0;
`endif

  embedded_system_led_sequencer dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    vectors++; if (out_port !== 10'h000) begin miscompares++; $display("FAIL reset_out got %h want 000", out_port); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq); end
    rd(3'd2, r);
    vectors++; if (r !== 32'd5000000) begin miscompares++; $display("FAIL reset_period got %0d want 5000000", r); end
    rd(3'd4, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL reset_status got %h want 0", r); end
    rd(3'd0, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl got %h want 0", r); end
  endtask

  task automatic test_direct();
    logic [31:0] r;
    wr(3'd1, 32'h2A5);
    vectors++; if (out_port !== 10'h000) begin miscompares++; $display("FAIL direct_early got %h want 000", out_port); end
    step();
    vectors++; if (out_port !== 10'h2A5) begin miscompares++; $display("FAIL direct_out got %h want 2a5", out_port); end
    rd(3'd1, r);
    vectors++; if (r !== 32'h2A5) begin miscompares++; $display("FAIL direct_rd got %h want 2a5", r); end
  endtask

  task automatic test_blink();
    logic [31:0] r;
    logic [9:0]  exp;
    wr(3'd2, 32'd3);
    wr(3'd1, 32'h0F0);
    wr(3'd0, 32'h0D);
    for (int i = 1; i <= 12; i++) begin
      step();
      exp = (((i - 1) / 3) % 2 == 0) ? 10'h0F0 : 10'h000;
      vectors++; if (out_port !== exp) begin miscompares++; $display("FAIL blink_out edge %0d got %h want %h", i, out_port, exp); end
      rd(3'd4, r);
      vectors++; if (r[0] !== 1'b1) begin miscompares++; $display("FAIL blink_busy edge %0d got %b want 1", i, r[0]); end
    end
    rd(3'd0, r);
    vectors++; if (r !== 32'h25) begin miscompares++; $display("FAIL blink_ctrl got %h want 25", r); end
    wr(3'd0, 32'h10);
  endtask

  task automatic test_scan_oneshot();
    logic [31:0] r;
    int          p;
    wr(3'd2, 32'd1);
    wr(3'd3, 32'd20);
    wr(3'd0, 32'h0A | IRQ_BIT);
    for (int i = 1; i <= 21; i++) begin
      step();
      p = i - 1;
      p = (p <= 9) ? p : ((p <= 18) ? 18 - p : p - 18);
      vectors++; if (out_port !== (10'h001 << p)) begin miscompares++; $display("FAIL scan_out edge %0d got %h want %h", i, out_port, 10'h001 << p); end
      if (i == 19 || i == 20) begin
        rd(3'd4, r);
        vectors++; if (r[1] !== (i == 20)) begin miscompares++; $display("FAIL scan_done edge %0d got %b want %b", i, r[1], i == 20); end
      end
    end
    step(); step();
    vectors++; if (out_port !== 10'h004) begin miscompares++; $display("FAIL scan_hold got %h want 004", out_port); end
    rd(3'd0, r);
    vectors++; if (r !== (32'h42 | IRQ_BIT)) begin miscompares++; $display("FAIL scan_ctrl got %h want %h", r, 32'h42 | IRQ_BIT); end
    rd(3'd4, r);
    vectors++; if (r !== 32'h1402) begin miscompares++; $display("FAIL scan_status got %h want 1402", r); end
    vectors++; if (irq !== EXP_IRQ) begin miscompares++; $display("FAIL scan_irq got %b want %b", irq, EXP_IRQ); end
    wr(3'd4, 32'h2);
    rd(3'd4, r);
    vectors++; if (r !== 32'h1400) begin miscompares++; $display("FAIL done_clear got %h want 1400", r); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL clear_irq got %b want 0", irq); end
  endtask

  task automatic test_bar_stop();
    logic [31:0] r;
    logic [9:0]  exp;
    wr(3'd0, 32'h10);
    wr(3'd2, 32'd2);
    wr(3'd0, 32'h0F);
    for (int i = 1; i <= 11; i++) begin
      step();
      exp = 10'((11'd1 << ((i - 1) / 2)) - 11'd1);
      vectors++; if (out_port !== exp) begin miscompares++; $display("FAIL bar_out edge %0d got %h want %h", i, out_port, exp); end
    end
    wr(3'd0, 32'h10);
    vectors++; if (out_port !== 10'h01F) begin miscompares++; $display("FAIL stop_last got %h want 01f", out_port); end
    rd(3'd0, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL stop_ctrl got %h want 0", r); end
    step();
    vectors++; if (out_port !== 10'h0F0) begin miscompares++; $display("FAIL stop_direct got %h want 0f0", out_port); end
    rd(3'd4, r);
    vectors++; if (r !== 32'h0500) begin miscompares++; $display("FAIL stop_steps got %h want 0500", r); end
    wr(3'd0, 32'h18);
    rd(3'd0, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL stopstart_ctrl got %h want 0", r); end
    rd(3'd4, r);
    vectors++; if (r !== 32'h0500) begin miscompares++; $display("FAIL stopstart_status got %h want 0500", r); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] r;
    wr(3'd0, 32'h0F);
    for (int i = 0; i < 7; i++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    vectors++; if (out_port !== 10'h000) begin miscompares++; $display("FAIL midrst_out got %h want 000", out_port); end
    rd(3'd0, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL midrst_ctrl got %h want 0", r); end
    rd(3'd2, r);
    vectors++; if (r !== 32'd5000000) begin miscompares++; $display("FAIL midrst_period got %0d want 5000000", r); end
    rd(3'd4, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL midrst_status got %h want 0", r); end
    step();
    vectors++; if (out_port !== 10'h000) begin miscompares++; $display("FAIL midrst_after got %h want 000", out_port); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_blink();
    test_scan_oneshot();
    test_bar_stop();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
